// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared types and helpers for the one-hot hold decoder.
//   dec_state_t : decoder FSM states (IDLE, HOLD)
//   onehot()    : binary index to one-hot vector, 1 << idx
package onehot_dec_pkg;

    typedef enum logic {IDLE, HOLD} dec_state_t;

    localparam int MAX_AW = 5;
    localparam int MAX_N  = 1 << MAX_AW;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_AW-1:0] idx);
        return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/onehot_hold_dec.sv
// onehot_hold_dec: registered binary-to-one-hot decoder that holds each strobe
// for HOLD_CYCLES clocks, with a valid/ready handshake and a synchronous abort.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   a        in   encoded index [AW-1:0]
//   in_valid in   a is valid this cycle
//   in_ready out  decoder can accept a this cycle
//   clr      in   synchronous abort of current strobe and pending entry
//   y        out  one-hot strobe [2**AW-1:0], zero when idle
//   y_valid  out  y is non-zero
//   busy     out  holding a strobe or a pending entry
// Define ONEHOT_DEC_PEND_EN to add a one-entry pending register that accepts a
// request mid-hold and launches it with no gap when the current hold ends.
module onehot_hold_dec
    import onehot_dec_pkg::*;
#(
    parameter int AW          = 2,
    parameter int HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     a,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clr,
    output logic [(1<<AW)-1:0] y,
    output logic              y_valid,
    output logic              busy
);

    localparam int N  = 1 << AW;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    dec_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  y_q, y_d;
    logic          rdy_q;
    logic          done, acc, launch;
    logic [AW-1:0] launch_a;

    // Last hold cycle (or idle): the next edge may start a new strobe.
    assign done = (state_q == IDLE) || (cnt_q == '0);
    assign acc  = in_valid && in_ready;

`ifdef ONEHOT_DEC_PEND_EN
    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_a_q, pend_a_d;

    assign in_ready = rdy_q && !pend_valid_q && !clr;
    assign busy     = (state_q == HOLD) || pend_valid_q;

    // A stored request takes priority at the end of a hold; while it is
    // stored in_ready is low, so it can never collide with a fresh accept.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_a_d     = pend_a_q;
        launch       = acc && done;
        launch_a     = a;
        if (clr) begin
            pend_valid_d = 1'b0;
        end else if (done && pend_valid_q) begin
            launch       = 1'b1;
            launch_a     = pend_a_q;
            pend_valid_d = 1'b0;
        end else if (!done && acc) begin
            pend_valid_d = 1'b1;
            pend_a_d     = a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_a_q     <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_a_q     <= pend_a_d;
        end
    end
`else
    assign in_ready = rdy_q && done && !clr;
    assign busy     = (state_q == HOLD);
    assign launch   = acc;
    assign launch_a = a;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
        end else if (launch) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            y_d     = N'(onehot(MAX_AW'(launch_a)));
        end else if (!done) begin
            cnt_d   = cnt_q - 1'b1;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
        end
    end

    // rdy_q keeps in_ready low during reset and for the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rdy_q   <= 1'b1;
        end
    end

    assign y       = y_q;
    assign y_valid = |y_q;

endmodule

// File: tb/tb_onehot_hold_dec.sv
// tb_onehot_hold_dec: self-checking bench for onehot_hold_dec.
// The reference model is a queue of the y values still to be shown: each
// accept appends HOLD_CYCLES copies of 1<<a, every edge consumes one entry.
module tb_onehot_hold_dec;

    localparam int AW = 2;
    localparam int N  = 1 << AW;
    localparam int HC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a = '0;
    logic          in_valid = 1'b0;
    logic          clr = 1'b0;
    logic          in_ready, y_valid, busy;
    logic [N-1:0]  y;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] q[$];
    bit           up = 1'b0;

    always #5 clk = ~clk;

    onehot_hold_dec #(.AW(AW), .HOLD_CYCLES(HC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clr      (clr),
        .y        (y),
        .y_valid  (y_valid),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Without pending storage a new request fits only when at most the
    // current (last) cycle is queued; with it, only while no second strobe
    // is already queued behind the current one.
    function automatic bit mdl_ready(input logic c);
`ifdef ONEHOT_DEC_PEND_EN
        return up && !c && (q.size() <= HC);
`else
        return up && !c && (q.size() <= 1);
`endif
    endfunction

    task automatic step(input logic v, input logic [AW-1:0] ai, input logic c);
        logic [N-1:0] e;
        bit r;
        @(negedge clk);
        e = (q.size() != 0) ? q[0] : '0;
        check("y", y, e);
        check("y_valid", y_valid, q.size() != 0);
        check("busy", busy, q.size() != 0);
        check("onehot0", $onehot0(y), 1);
        in_valid = v;
        a        = ai;
        clr      = c;
        #1;
        r = mdl_ready(c);
        check("in_ready", in_ready, r);
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (c) q.delete();
        else if (v && r) repeat (HC) q.push_back(N'(1) << ai);
    endtask

    initial begin
        #2;
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 0);
        @(posedge clk);
        up = 1'b1;

        // Single strobe, then async reset in the middle of the hold.
        step(1'b1, 2'd2, 1'b0);
        @(negedge clk);
        check("mid_y", y, 4'b0100);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y", y, 0);
        check("arst_y_valid", y_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        q.delete();
        up = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel2_in_ready", in_ready, 0);
        @(posedge clk);
        up = 1'b1;

        // Full single strobe.
        step(1'b1, 2'd2, 1'b0);
        repeat (4) step(1'b0, 2'd0, 1'b0);
        // Back-to-back: second request presented in the last hold cycle.
        step(1'b1, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        repeat (4) step(1'b0, 2'd0, 1'b0);
        // Same index twice in a row.
        step(1'b1, 2'd2, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd2, 1'b0);
        repeat (4) step(1'b0, 2'd0, 1'b0);
        // Abort on hold cycle 2 with a simultaneous request.
        step(1'b1, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd0, 1'b1);
        repeat (2) step(1'b0, 2'd0, 1'b0);
        // Sweep all indices with gaps.
        for (int i = 0; i < N; i++) begin
            step(1'b1, AW'(i), 1'b0);
            repeat (4) step(1'b0, 2'd0, 1'b0);
        end
        // Request in hold cycle 1 (stored when pending storage is built in).
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        repeat (7) step(1'b0, 2'd0, 1'b0);
        // Random traffic.
        repeat (600)
            step(($urandom % 3) != 0, AW'($urandom), ($urandom % 16) == 0);
        step(1'b0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
